// File: rtl/hazard_fwd_unit.sv
// hazard_fwd_unit: pipeline hazard and forwarding controller.
//
// An internal scoreboard keeps one entry per post-ID stage. Slot 0 is EXE,
// slot 1 is MEM, and so on. Each entry holds {v, rd, wreg, m2reg}. From the
// scoreboard and the ID-stage operands the block produces, in the same cycle:
// operand forwarding selects, the load-use stall, issue, and the taken-branch
// flush. Branches are predicted not-taken, and wrong-path work is squashed
// when br_taken arrives.
//
// Optional feature: define HAZARD_PERF_EN to add three free-running 32-bit
// event counters (stall cycles, flush cycles, issued cycles that forward).
module hazard_fwd_unit #(
    parameter  int REG_AW    = 5,
    parameter  int FWD_DEPTH = 2,
    parameter  int LOAD_LAT  = 1,
    parameter  int RES_SLOT  = 0,
    localparam int FSW       = $clog2(FWD_DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic              id_rs1_en,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_rs2_en,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_wreg,
    input  logic              id_m2reg,
    input  logic              br_taken,
    output logic [FSW-1:0]    fwd_a_sel,
    output logic [FSW-1:0]    fwd_b_sel,
    output logic              stall,
    output logic              issue,
    output logic              flush_id
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0]       perf_stall_cnt,
    output logic [31:0]       perf_flush_cnt,
    output logic [31:0]       perf_fwd_cnt
`endif
);

    // Result of searching the scoreboard for one source operand.
    // The early_load flag marks a load whose data is not ready yet.
    typedef struct packed {
        logic           hit;
        logic           early_load;
        logic [FSW-1:0] sel;
    } match_t;

    // Scoreboard. Only the valid bits are control state. The payload fields
    // are plain data and are ignored whenever the matching valid bit is clear.
    logic [FWD_DEPTH-1:0] sb_v;
    logic [FWD_DEPTH-1:0] sb_wreg;
    logic [FWD_DEPTH-1:0] sb_m2reg;
    logic [REG_AW-1:0]    sb_rd [FWD_DEPTH];

    logic [FWD_DEPTH-1:0] eff_wr;
    logic                 rs1_live;
    logic                 rs2_live;
    match_t               match_a;
    match_t               match_b;
    logic                 hazard_a;
    logic                 hazard_b;

    // Find the youngest slot (lowest index) that writes register rs.
    // Older writers of the same register are shadowed by the younger one.
    function automatic match_t find_youngest(
        input logic [REG_AW-1:0]    rs,
        input logic [FWD_DEPTH-1:0] wr_mask,
        input logic [FWD_DEPTH-1:0] ld_mask,
        input logic [REG_AW-1:0]    rd_tab [FWD_DEPTH]
    );
        match_t m;
        m = '0;
        // Scan from the oldest slot to the youngest, so the youngest hit wins.
        for (int k = FWD_DEPTH - 1; k >= 0; k--) begin
            if (wr_mask[k] && (rd_tab[k] == rs)) begin
                m.hit        = 1'b1;
                m.early_load = ld_mask[k] && (k < LOAD_LAT);
                m.sel        = FSW'(k + 1);
            end
        end
        return m;
    endfunction

    // A slot really writes the register file only if it is valid, has
    // wreg set, and targets a register other than r0.
    always_comb begin
        eff_wr = '0;
        for (int k = 0; k < FWD_DEPTH; k++) begin
            eff_wr[k] = sb_v[k] & sb_wreg[k] & (sb_rd[k] != '0);
        end
    end

    // Operand search. Reads of r0 and disabled operands never match.
    always_comb begin
        rs1_live = id_valid & id_rs1_en & (id_rs1 != '0);
        rs2_live = id_valid & id_rs2_en & (id_rs2 != '0);
        match_a  = find_youngest(id_rs1, eff_wr, sb_m2reg, sb_rd);
        match_b  = find_youngest(id_rs2, eff_wr, sb_m2reg, sb_rd);
    end

    // Forward selects and load-use hazards. An operand that is still waiting
    // on a load reads the register file (select 0) and the instruction stalls.
    always_comb begin
        hazard_a  = rs1_live & match_a.hit & match_a.early_load;
        hazard_b  = rs2_live & match_b.hit & match_b.early_load;
        fwd_a_sel = (rs1_live & match_a.hit & ~match_a.early_load) ? match_a.sel : '0;
        fwd_b_sel = (rs2_live & match_b.hit & ~match_b.early_load) ? match_b.sel : '0;
    end

    // A taken branch overrides any stall: the stalled instruction is squashed.
    assign stall    = (hazard_a | hazard_b) & ~br_taken;
    assign issue    = id_valid & ~stall & ~br_taken;
    assign flush_id = br_taken;

    // ---- Stage boundary: ID -> scoreboard slot 0; slot k-1 -> slot k ----

    // Valid bits: shift down the pipe. Slot 0 takes a bubble on a stall or
    // a flush. On a taken branch, the entries younger than the resolving
    // branch (old slots 0..RES_SLOT-1) are squashed as they shift.
    always_ff @(posedge clk) begin
        if (rst) begin
            sb_v <= '0;
        end else begin
            sb_v[0] <= issue;
            for (int k = 1; k < FWD_DEPTH; k++) begin
                if (br_taken && (k <= RES_SLOT)) begin
                    sb_v[k] <= 1'b0;
                end else begin
                    sb_v[k] <= sb_v[k-1];
                end
            end
        end
    end

    // Payload fields: shift every cycle. No reset is needed because the
    // valid bits gate every use of these fields.
    always_ff @(posedge clk) begin
        sb_rd[0]    <= id_rd;
        sb_wreg[0]  <= id_wreg;
        sb_m2reg[0] <= id_m2reg;
        for (int k = 1; k < FWD_DEPTH; k++) begin
            sb_rd[k]    <= sb_rd[k-1];
            sb_wreg[k]  <= sb_wreg[k-1];
            sb_m2reg[k] <= sb_m2reg[k-1];
        end
    end

`ifdef HAZARD_PERF_EN
    // Event counters. They wrap naturally at 2^32 and clear on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stall_cnt <= '0;
            perf_flush_cnt <= '0;
            perf_fwd_cnt   <= '0;
        end else begin
            if (stall) begin
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            end
            if (br_taken) begin
                perf_flush_cnt <= perf_flush_cnt + 32'd1;
            end
            if (issue && ((fwd_a_sel != '0) || (fwd_b_sel != '0))) begin
                perf_fwd_cnt <= perf_fwd_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Testbench for hazard_fwd_unit. Three instances share one set of ID inputs:
//   u_def : default parameters
//   u_ll  : FWD_DEPTH=3, LOAD_LAT=2
//   u_br  : RES_SLOT=1
// Each test first resets, then observes only the instance it targets.
module tb_hazard_fwd_unit;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1;
    logic       id_valid = 1'b0;
    logic [4:0] id_rs1 = '0;
    logic       id_rs1_en = 1'b0;
    logic [4:0] id_rs2 = '0;
    logic       id_rs2_en = 1'b0;
    logic [4:0] id_rd = '0;
    logic       id_wreg = 1'b0;
    logic       id_m2reg = 1'b0;
    logic       br_taken = 1'b0;

    logic [1:0] a_sel   [3];
    logic [1:0] b_sel   [3];
    logic       stall_o [3];
    logic       issue_o [3];
    logic       flush_o [3];
`ifdef HAZARD_PERF_EN
    logic [31:0] pstall [3];
    logic [31:0] pflush [3];
    logic [31:0] pfwd   [3];
`endif

    hazard_fwd_unit u_def (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs1_en(id_rs1_en), .id_rs2(id_rs2), .id_rs2_en(id_rs2_en),
        .id_rd(id_rd), .id_wreg(id_wreg), .id_m2reg(id_m2reg), .br_taken(br_taken),
        .fwd_a_sel(a_sel[0]), .fwd_b_sel(b_sel[0]), .stall(stall_o[0]),
        .issue(issue_o[0]), .flush_id(flush_o[0])
`ifdef HAZARD_PERF_EN
        , .perf_stall_cnt(pstall[0]), .perf_flush_cnt(pflush[0]), .perf_fwd_cnt(pfwd[0])
`endif
    );

    hazard_fwd_unit #(.FWD_DEPTH(3), .LOAD_LAT(2)) u_ll (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs1_en(id_rs1_en), .id_rs2(id_rs2), .id_rs2_en(id_rs2_en),
        .id_rd(id_rd), .id_wreg(id_wreg), .id_m2reg(id_m2reg), .br_taken(br_taken),
        .fwd_a_sel(a_sel[1]), .fwd_b_sel(b_sel[1]), .stall(stall_o[1]),
        .issue(issue_o[1]), .flush_id(flush_o[1])
`ifdef HAZARD_PERF_EN
        , .perf_stall_cnt(pstall[1]), .perf_flush_cnt(pflush[1]), .perf_fwd_cnt(pfwd[1])
`endif
    );

    hazard_fwd_unit #(.RES_SLOT(1)) u_br (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs1_en(id_rs1_en), .id_rs2(id_rs2), .id_rs2_en(id_rs2_en),
        .id_rd(id_rd), .id_wreg(id_wreg), .id_m2reg(id_m2reg), .br_taken(br_taken),
        .fwd_a_sel(a_sel[2]), .fwd_b_sel(b_sel[2]), .stall(stall_o[2]),
        .issue(issue_o[2]), .flush_id(flush_o[2])
`ifdef HAZARD_PERF_EN
        , .perf_stall_cnt(pstall[2]), .perf_flush_cnt(pflush[2]), .perf_fwd_cnt(pfwd[2])
`endif
    );

    typedef struct packed {
        logic       v;
        logic [4:0] rs1;
        logic       e1;
        logic [4:0] rs2;
        logic       e2;
        logic [4:0] rd;
        logic       w;
        logic       m;
        logic       br;
        logic [1:0] ea;
        logic [1:0] eb;
        logic       es;
        logic       ei;
    } step_t;

    // Output fields, in order: fwd_a, fwd_b, stall, issue, flush
    typedef struct packed {
        logic [1:0] a;
        logic [1:0] b;
        logic       s;
        logic       i;
        logic       f;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   dut_sel = 0;
    exp_t obs;

    always_comb begin
        obs = exp_t'({a_sel[dut_sel], b_sel[dut_sel], stall_o[dut_sel],
                      issue_o[dut_sel], flush_o[dut_sel]});
    end

    function automatic step_t mk(int v, int rs1, int e1, int rs2, int e2, int rd, int w,
                                 int m, int br, int ea, int eb, int es, int ei);
        step_t s;
        s.v = 1'(v);   s.rs1 = 5'(rs1); s.e1 = 1'(e1); s.rs2 = 5'(rs2); s.e2 = 1'(e2);
        s.rd = 5'(rd); s.w = 1'(w);     s.m = 1'(m);   s.br = 1'(br);
        s.ea = 2'(ea); s.eb = 2'(eb);   s.es = 1'(es); s.ei = 1'(ei);
        return s;
    endfunction

    // Drive one ID cycle just after the clock edge and queue its expected outputs.
    task automatic apply(input step_t st);
        @(posedge clk); #1;
        rst = 1'b0;
        id_valid = st.v;  id_rs1 = st.rs1; id_rs1_en = st.e1; id_rs2 = st.rs2;
        id_rs2_en = st.e2; id_rd = st.rd;  id_wreg = st.w;    id_m2reg = st.m;
        br_taken = st.br;
        exp_q.push_back(exp_t'({st.ea, st.eb, st.es, st.ei, st.br}));
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1; id_valid = 1'b0; br_taken = 1'b0;
        exp_q.delete();
    endtask

    task automatic test_reset();
        step_t s[3];
        exp_t  e;
        dut_sel = 0;
        s[0] = mk(1, 0, 0, 0, 0, 3, 1, 0, 0, 0, 0, 0, 1);
        s[1] = mk(1, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        s[2] = mk(1, 3, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        do_reset();
        apply(s[0]); #4;
        e = exp_q.pop_front(); total++;
        if (obs !== e) begin bad++; $display("FAIL reset_pre got=%b required=%b", obs, e); end
        do_reset();
        for (int i = 1; i < 3; i++) begin
            apply(s[i]); #4;
            e = exp_q.pop_front(); total++;
            if (obs !== e) begin bad++; $display("FAIL reset[%0d] got=%b required=%b", i, obs, e); end
        end
    endtask

    task automatic test_fwd_exe_mem();
        step_t s[4];
        exp_t  e;
        dut_sel = 0;
        s[0] = mk(1, 0, 0, 0, 0, 3, 1, 0, 0, 0, 0, 0, 1);
        s[1] = mk(1, 3, 1, 0, 0, 10, 1, 0, 0, 1, 0, 0, 1);
        s[2] = mk(1, 3, 1, 0, 0, 0, 0, 0, 0, 2, 0, 0, 1);
        s[3] = mk(1, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        do_reset();
        foreach (s[i]) begin
            apply(s[i]); #4;
            e = exp_q.pop_front(); total++;
            if (obs !== e) begin bad++; $display("FAIL fwd_exe_mem[%0d] got=%b required=%b", i, obs, e); end
        end
    endtask

    task automatic test_load_use();
        step_t s[4];
        exp_t  e;
        dut_sel = 0;
        s[0] = mk(1, 0, 0, 0, 0, 5, 1, 1, 0, 0, 0, 0, 1);
        s[1] = mk(1, 0, 0, 5, 1, 6, 1, 0, 0, 0, 0, 1, 0);
        s[2] = mk(1, 0, 0, 5, 1, 6, 1, 0, 0, 0, 2, 0, 1);
        s[3] = mk(1, 6, 1, 5, 1, 0, 0, 0, 0, 1, 0, 0, 1);
        do_reset();
        foreach (s[i]) begin
            apply(s[i]); #4;
            e = exp_q.pop_front(); total++;
            if (obs !== e) begin bad++; $display("FAIL load_use[%0d] got=%b required=%b", i, obs, e); end
        end
`ifdef HAZARD_PERF_EN
        @(posedge clk); #1;
        total++;
        if ({pstall[0], pflush[0], pfwd[0]} !== {32'd1, 32'd0, 32'd2}) begin
            bad++;
            $display("FAIL perf_counts got=%0d/%0d/%0d required=1/0/2", pstall[0], pflush[0], pfwd[0]);
        end
`endif
    endtask

    task automatic test_youngest();
        step_t s[6];
        exp_t  e;
        dut_sel = 0;
        s[0] = mk(1, 0, 0, 0, 0, 4, 1, 0, 0, 0, 0, 0, 1);
        s[1] = mk(1, 0, 0, 0, 0, 4, 1, 0, 0, 0, 0, 0, 1);
        s[2] = mk(1, 4, 1, 4, 1, 0, 1, 0, 0, 1, 1, 0, 1);
        s[3] = mk(1, 0, 1, 4, 1, 9, 1, 0, 0, 0, 2, 0, 1);
        s[4] = mk(0, 9, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        s[5] = mk(1, 9, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        do_reset();
        foreach (s[i]) begin
            apply(s[i]); #4;
            e = exp_q.pop_front(); total++;
            if (obs !== e) begin bad++; $display("FAIL youngest[%0d] got=%b required=%b", i, obs, e); end
        end
    endtask

    task automatic test_load_lat2();
        step_t s[5];
        exp_t  e;
        dut_sel = 1;
        s[0] = mk(1, 0, 0, 0, 0, 7, 1, 1, 0, 0, 0, 0, 1);
        s[1] = mk(1, 7, 1, 0, 0, 8, 1, 0, 0, 0, 0, 1, 0);
        s[2] = mk(1, 7, 1, 0, 0, 8, 1, 0, 0, 0, 0, 1, 0);
        s[3] = mk(1, 7, 1, 0, 0, 8, 1, 0, 0, 3, 0, 0, 1);
        s[4] = mk(1, 8, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1);
        do_reset();
        foreach (s[i]) begin
            apply(s[i]); #4;
            e = exp_q.pop_front(); total++;
            if (obs !== e) begin bad++; $display("FAIL load_lat2[%0d] got=%b required=%b", i, obs, e); end
        end
    endtask

    task automatic test_flush();
        step_t s[3];
        exp_t  e;
        // Branch resolving in EXE: the load is older and survives into slot 1.
        dut_sel = 0;
        s[0] = mk(1, 0, 0, 0, 0, 5, 1, 1, 0, 0, 0, 0, 1);
        s[1] = mk(1, 0, 0, 5, 1, 6, 1, 0, 1, 0, 0, 0, 0);
        s[2] = mk(1, 0, 0, 5, 1, 6, 1, 0, 0, 0, 2, 0, 1);
        do_reset();
        foreach (s[i]) begin
            apply(s[i]); #4;
            e = exp_q.pop_front(); total++;
            if (obs !== e) begin bad++; $display("FAIL flush_res0[%0d] got=%b required=%b", i, obs, e); end
        end
        // Branch resolving in MEM: the load in EXE is on the wrong path and is squashed.
        dut_sel = 2;
        s[2] = mk(1, 0, 0, 5, 1, 6, 1, 0, 0, 0, 0, 0, 1);
        do_reset();
        foreach (s[i]) begin
            apply(s[i]); #4;
            e = exp_q.pop_front(); total++;
            if (obs !== e) begin bad++; $display("FAIL flush_res1[%0d] got=%b required=%b", i, obs, e); end
        end
    endtask

    task automatic test_reset_mid_stall();
        step_t s[3];
        exp_t  e;
        dut_sel = 1;
        s[0] = mk(1, 0, 0, 0, 0, 7, 1, 1, 0, 0, 0, 0, 1);
        s[1] = mk(1, 7, 1, 0, 0, 8, 1, 0, 0, 0, 0, 1, 0);
        s[2] = mk(1, 7, 1, 0, 0, 8, 1, 0, 0, 0, 0, 0, 1);
        do_reset();
        for (int i = 0; i < 2; i++) begin
            apply(s[i]); #4;
            e = exp_q.pop_front(); total++;
            if (obs !== e) begin bad++; $display("FAIL mid_stall[%0d] got=%b required=%b", i, obs, e); end
        end
        // Reset lands during the second stall cycle, with the reader held in ID.
        @(posedge clk); #1;
        rst = 1'b1;
        apply(s[2]); #4;
        e = exp_q.pop_front(); total++;
        if (obs !== e) begin bad++; $display("FAIL mid_stall_rst got=%b required=%b", obs, e); end
`ifdef HAZARD_PERF_EN
        total++;
        if ({pstall[1], pflush[1], pfwd[1]} !== 96'd0) begin
            bad++;
            $display("FAIL perf_rst got=%0d/%0d/%0d required=0/0/0", pstall[1], pflush[1], pfwd[1]);
        end
`endif
    endtask

    task automatic test_back_to_back();
        step_t s[6];
        exp_t  e;
        dut_sel = 0;
        s[0] = mk(1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 1);
        s[1] = mk(1, 1, 1, 0, 0, 2, 1, 0, 0, 1, 0, 0, 1);
        s[2] = mk(1, 1, 1, 2, 1, 3, 1, 0, 0, 2, 1, 0, 1);
        s[3] = mk(1, 3, 1, 0, 0, 4, 1, 1, 0, 1, 0, 0, 1);
        s[4] = mk(1, 4, 1, 3, 1, 5, 1, 0, 0, 0, 2, 1, 0);
        s[5] = mk(1, 4, 1, 3, 1, 5, 1, 0, 0, 2, 0, 0, 1);
        do_reset();
        foreach (s[i]) begin
            apply(s[i]); #4;
            e = exp_q.pop_front(); total++;
            if (obs !== e) begin bad++; $display("FAIL back_to_back[%0d] got=%b required=%b", i, obs, e); end
        end
    endtask

    initial begin
        test_reset();
        test_fwd_exe_mem();
        test_load_use();
        test_youngest();
        test_load_lat2();
        test_flush();
        test_reset_mid_stall();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hazard_fwd_unit.md
Name: hazard_fwd_unit

Overview:
- Parametrised pipeline hazard and forwarding controller for the in-order MIPS-style core.
- Holds an internal scoreboard of in-flight destination registers, one slot per post-ID stage.
- Computes operand forwarding selects, multi-cycle load-use stalls and taken-branch flushes.
- Replaces the current stall-on-every-branch policy with predict-not-taken plus flush, and supports configurable forwarding depth and load latency.

Parameters:
- REG_AW, 5: register address width.
- FWD_DEPTH, 2: number of scoreboard slots. Slot 0 = EXE, slot 1 = MEM, and so on. Range 1..4.
- LOAD_LAT, 1: first slot index at which load data can be forwarded. Range 1..FWD_DEPTH.
- RES_SLOT, 0: slot in which branches resolve. Range 0..FWD_DEPTH-1.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- id_valid  in  1  the ID stage holds a real instruction.
- id_rs1  in  REG_AW  first source register.
- id_rs1_en  in  1  the instruction reads rs1.
- id_rs2  in  REG_AW  second source register.
- id_rs2_en  in  1  the instruction reads rs2.
- id_rd  in  REG_AW  destination register.
- id_wreg  in  1  the instruction writes the register file.
- id_m2reg  in  1  the instruction is a load.
- br_taken  in  1  a branch resolved taken in slot RES_SLOT this cycle.
- fwd_a_sel  out  FSW  rs1 source. FSW = $clog2(FWD_DEPTH+1). 0 = register file; k+1 = slot k.
- fwd_b_sel  out  FSW  rs2 source, same encoding as fwd_a_sel.
- stall  out  1  hold PC and the IF/ID register.
- issue  out  1  the ID instruction advances into EXE this cycle.
- flush_id  out  1  squash IF/ID; the front end redirects.

Behaviour:
- Scoreboard slot contents: {v, rd, wreg, m2reg}.
- Effective write: v & wreg & (rd != 0). Register 0 never creates a hazard or a forward.
- Operand match, rs1 (rs2 identical with its own enable):
  - Applies only when id_valid & id_rs1_en & id_rs1 != 0.
  - Select the youngest (lowest k) slot with an effective write and rd == id_rs1.
  - Older matches are ignored.
- Load-use hazard: the selected slot has m2reg = 1 and k < LOAD_LAT.
- Forwarding output:
  - No match or a hazard: fwd_x_sel = 0.
  - Otherwise: fwd_x_sel = k+1.
- Outputs are combinational from the scoreboard and the ID inputs:
  - stall = (hazard_a | hazard_b) & ~br_taken.
  - issue = id_valid & ~stall & ~br_taken.
  - flush_id = br_taken.
- Clock update, when not in reset:
  - Slots k >= 1 take slot k-1.
  - Slot 0 takes {issue, id_rd, id_wreg, id_m2reg}. When stalled, a bubble with v = 0 enters.
- br_taken update:
  - Slots 0..RES_SLOT-1 are invalidated after the shift, i.e. the younger wrong-path instructions.
  - The resolving branch and older slots shift normally.
  - Slot 0 receives a bubble.
- Load-use with LOAD_LAT = L: stall lasts exactly L - k cycles for a load in slot k; then forwarding comes from slot L.
- br_taken coinciding with a hazard: flush wins. stall = 0, issue = 0, and no hazard state persists.
- Reset: all slot v = 0, so the outputs settle to fwd sel = 0, stall = 0, issue = id_valid, flush_id = br_taken.
- Reset while stalled or mid-flush: the next cycle starts with an empty scoreboard and no residual stall.
- Latency: forwarding selects are valid in the same cycle as the ID inputs. The scoreboard updates one cycle later.

Optional Feature:
- Macro: HAZARD_PERF_EN.
- When defined, the block adds three outputs:
  - perf_stall_cnt, 32 bits: +1 on each stall cycle.
  - perf_flush_cnt, 32 bits: +1 on each br_taken cycle.
  - perf_fwd_cnt, 32 bits: +1 on each issued cycle with a nonzero fwd_a_sel or fwd_b_sel.
- Counters clear on rst and wrap modulo 2^32.
- When not defined, these ports and registers are absent and the remaining behaviour is identical.

Test Plan:
- Defaults. Issue add r3 (wreg); next cycle ID reads rs1 = r3 -> fwd_a_sel = 1, stall = 0. One cycle later, with one independent instruction in between -> fwd_a_sel = 2.
- Defaults. Issue lw r5; next ID reads rs2 = r5 -> stall = 1 for exactly 1 cycle, issue = 0, slot-0 bubble; following cycle fwd_b_sel = 2, issue = 1.
- LOAD_LAT = 2, FWD_DEPTH = 3. lw r7 followed immediately by a reader of r7 -> stall for 2 cycles, then fwd_a_sel = 3.
- add r4 then sub r4, then a reader of r4 -> fwd select points to slot 0 (youngest). ID reads r0 while a slot writes r0 -> sel = 0, stall = 0.
- RES_SLOT = 1, FWD_DEPTH = 2. Assert br_taken while a load-use stall is pending -> flush_id = 1, stall = 0, issue = 0; next cycle slot 0 invalid; the reader no longer stalls.
- Assert rst during a 2-cycle load stall -> next cycle stall = 0, fwd sels = 0, all slots empty. With HAZARD_PERF_EN defined, the counters read 0.
